// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-control bundle: instruction flags and branch target in, PC and status out.
// The master drives the flags (core/testbench) and the slave is the fetch stage.
interface pc_fetch_ctrl_if #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
);
  logic             Start;
  logic             Halt;
  logic             Jump;
  logic             Taken;
  logic             Call;
  logic             Ret;
  logic [PC_W-1:0]  Target;
  logic [PC_W-1:0]  ProgCtr;
  logic             Running;
  logic             Done;
  logic             StackErr;
  logic [CNT_W-1:0] InstCount;

  modport master (
    output Start, Halt, Jump, Taken, Call, Ret, Target,
    input  ProgCtr, Running, Done, StackErr, InstCount
  );

  modport slave (
    input  Start, Halt, Jump, Taken, Call, Ret, Target,
    output ProgCtr, Running, Done, StackErr, InstCount
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Program-counter / fetch-control stage: IDLE/RUN/HALT sequencing, branch/call/return
// next-PC selection, a small hardware return stack and a saturating retire counter.
module pc_fetch_ctrl #(
  parameter int PC_W     = 10,
  parameter int DEPTH    = 4,
  parameter int START_PC = 0,
  parameter int CNT_W    = 16
) (
  input logic            Clk,
  input logic            Reset,
  pc_fetch_ctrl_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int SP_W  = IDX_W + 1;
  localparam logic [SP_W-1:0]  SP_FULL = SP_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [PC_W-1:0]  r_pc, w_pc_nxt, w_pc_inc;
  logic [SP_W-1:0]  r_sp, w_sp_nxt, w_sp_dec;
  logic             r_err, w_err_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_push;
  logic [PC_W-1:0]  r_stack [DEPTH];

  // Both wrap silently modulo their width; sp_dec is only used when sp>0.
  assign w_pc_inc = r_pc + PC_W'(1);
  assign w_sp_dec = r_sp - SP_W'(1);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge Clk) begin
    if (!Reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_sp_nxt    = r_sp;
    w_err_nxt   = r_err;
    w_cnt_nxt   = r_cnt;
    w_push      = 1'b0;
    case (r_state)
      S_IDLE, S_HALT: begin
        if (bus.Start) begin
          w_state_nxt = S_RUN;
          w_pc_nxt    = PC_W'(START_PC);
          w_sp_nxt    = '0;
          w_err_nxt   = 1'b0;
          w_cnt_nxt   = '0;
        end
      end
      S_RUN: begin
        w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
        if (bus.Halt) begin
          w_state_nxt = S_HALT;
        end else if (bus.Ret) begin
          if (r_sp != '0) begin
            w_pc_nxt = r_stack[w_sp_dec[IDX_W-1:0]];
            w_sp_nxt = w_sp_dec;
          end else begin
            w_err_nxt = 1'b1;
            w_pc_nxt  = w_pc_inc;
          end
        end else if (bus.Call) begin
          if (r_sp != SP_FULL) begin
            w_push   = 1'b1;
            w_sp_nxt = r_sp + SP_W'(1);
          end else begin
            w_err_nxt = 1'b1;
          end
          w_pc_nxt = bus.Target;
        end else if (bus.Jump && bus.Taken) begin
          w_pc_nxt = bus.Target;
        end else begin
          w_pc_nxt = w_pc_inc;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_pc  <= '0;
      r_sp  <= '0;
      r_err <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_pc  <= w_pc_nxt;
      r_sp  <= w_sp_nxt;
      r_err <= w_err_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  // NOTE: the stack array has no reset; sp alone defines which entries are valid,
  // so clearing the storage would only cost reset fan-out.
  always_ff @(posedge Clk) begin
    if (Reset && w_push) r_stack[r_sp[IDX_W-1:0]] <= w_pc_inc;
  end

  assign bus.ProgCtr   = r_pc;
  assign bus.Running   = (r_state == S_RUN);
  assign bus.Done      = (r_state == S_HALT);
  assign bus.StackErr  = r_err;
  assign bus.InstCount = r_cnt;
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed vector table, hand-written corner
// sequences, and randomized traffic compared against a queue-based reference model.
module tb_pc_fetch_ctrl;
  localparam int PC_W  = 10;
  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int PC_MOD  = 1 << PC_W;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic Clk;
  logic Reset;

  pc_fetch_ctrl_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  pc_fetch_ctrl #(
    .PC_W(PC_W), .DEPTH(DEPTH), .START_PC(0), .CNT_W(CNT_W)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .bus(bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state: plain integers and a queue used as the return stack.
  int m_pc, m_cnt;
  bit m_err, m_run, m_done;
  int m_stack[$];

  typedef struct {
    bit start, halt, jump, taken, call, ret;
    int target;
    int pc, cnt;
    bit err, run, done;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit s, bit h, bit j, bit t, bit c, bit r, int tg,
                              int pc, int cnt, bit err, bit run, bit done);
    vec_t v;
    v.start = s; v.halt = h; v.jump = j; v.taken = t; v.call = c; v.ret = r;
    v.target = tg; v.pc = pc; v.cnt = cnt; v.err = err; v.run = run; v.done = done;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_out(string tag, int pc, int cnt, bit err, bit run, bit done);
    check({tag, ".pc"},   32'(bus.ProgCtr),   pc);
    check({tag, ".cnt"},  32'(bus.InstCount), cnt);
    check({tag, ".err"},  32'(bus.StackErr),  32'(err));
    check({tag, ".run"},  32'(bus.Running),   32'(run));
    check({tag, ".done"}, 32'(bus.Done),      32'(done));
  endtask

  function automatic void model_step(bit rst_n, bit s, bit h, bit j, bit t, bit c,
                                     bit r, int tg);
    if (!rst_n) begin
      m_pc = 0; m_cnt = 0; m_err = 0; m_run = 0; m_done = 0;
      m_stack.delete();
    end else if (!m_run) begin
      if (s) begin
        m_run = 1; m_done = 0; m_pc = 0; m_cnt = 0; m_err = 0;
        m_stack.delete();
      end
    end else begin
      if (m_cnt < CNT_MAX) m_cnt++;
      if (h) begin
        m_run = 0; m_done = 1;
      end else if (r) begin
        if (m_stack.size() > 0) m_pc = m_stack.pop_back();
        else begin
          m_err = 1; m_pc = (m_pc + 1) % PC_MOD;
        end
      end else if (c) begin
        if (m_stack.size() < DEPTH) m_stack.push_back((m_pc + 1) % PC_MOD);
        else m_err = 1;
        m_pc = tg;
      end else if (j && t) begin
        m_pc = tg;
      end else begin
        m_pc = (m_pc + 1) % PC_MOD;
      end
    end
  endfunction

  // Drive one cycle of inputs, clock it in, and settle 1 time unit past the edge.
  task automatic apply(bit rst_n, bit s, bit h, bit j, bit t, bit c, bit r, int tg);
    Reset = rst_n;
    bus.Start = s; bus.Halt = h; bus.Jump = j; bus.Taken = t;
    bus.Call = c; bus.Ret = r; bus.Target = PC_W'(tg);
    @(posedge Clk);
    #1;
    model_step(rst_n, s, h, j, t, c, r, tg);
  endtask

  task automatic idle_step();
    apply(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    Reset = 1'b0;
    bus.Start = 0; bus.Halt = 0; bus.Jump = 0; bus.Taken = 0;
    bus.Call = 0; bus.Ret = 0; bus.Target = '0;

    // Reset for two cycles, then IDLE must ignore flow-control flags.
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    check_out("reset", 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      apply(1, 0, 1, 1, 1, 1, (i % 2 == 0) ? 1 : 0, 55);
      check("idle.pc", 32'(bus.ProgCtr), 0);
    end
    check_out("idle_end", 0, 0, 0, 0, 0);

    //          s h j t c r  tg    pc   cnt err run done
    tbl.push_back(mk(1,0,0,0,0,0,   0,    0,   0, 0, 1, 0));
    tbl.push_back(mk(0,0,0,0,0,0,   0,    1,   1, 0, 1, 0));
    tbl.push_back(mk(0,0,0,0,0,0,   0,    2,   2, 0, 1, 0));
    tbl.push_back(mk(0,0,0,0,0,0,   0,    3,   3, 0, 1, 0));
    tbl.push_back(mk(0,0,0,0,0,0,   0,    4,   4, 0, 1, 0));
    tbl.push_back(mk(0,0,0,0,0,0,   0,    5,   5, 0, 1, 0));
    tbl.push_back(mk(0,0,1,0,0,0, 999,    6,   6, 0, 1, 0));
    tbl.push_back(mk(0,0,1,1,0,0, 403,  403,   7, 0, 1, 0));
    tbl.push_back(mk(0,0,1,1,0,0,  20,   20,   8, 0, 1, 0));
    tbl.push_back(mk(0,0,0,0,1,0, 508,  508,   9, 0, 1, 0));
    tbl.push_back(mk(0,0,0,0,0,1,   0,   21,  10, 0, 1, 0));
    tbl.push_back(mk(0,0,0,0,1,0,  11,   11,  11, 0, 1, 0));
    tbl.push_back(mk(0,0,0,0,1,0, 179,  179,  12, 0, 1, 0));
    tbl.push_back(mk(0,0,0,0,1,0, 314,  314,  13, 0, 1, 0));
    tbl.push_back(mk(0,0,0,0,1,0, 318,  318,  14, 0, 1, 0));
    tbl.push_back(mk(0,0,0,0,1,0, 341,  341,  15, 1, 1, 0));
    tbl.push_back(mk(0,0,0,0,0,1,   0,  315,  16, 1, 1, 0));
    tbl.push_back(mk(0,0,0,0,0,1,   0,  180,  17, 1, 1, 0));
    tbl.push_back(mk(0,0,0,0,0,1,   0,   12,  18, 1, 1, 0));
    tbl.push_back(mk(0,0,0,0,0,1,   0,   22,  19, 1, 1, 0));
    tbl.push_back(mk(0,0,0,0,0,1,   0,   23,  20, 1, 1, 0));
    tbl.push_back(mk(0,0,1,1,0,0, 582,  582,  21, 1, 1, 0));
    tbl.push_back(mk(0,1,0,0,0,0,   0,  582,  22, 1, 0, 1));
    tbl.push_back(mk(0,0,1,1,1,0,   7,  582,  22, 1, 0, 1));
    tbl.push_back(mk(0,1,0,0,1,1,   9,  582,  22, 1, 0, 1));
    tbl.push_back(mk(1,0,0,0,0,0,   0,    0,   0, 0, 1, 0));
    tbl.push_back(mk(0,0,0,0,1,0, 100,  100,   1, 0, 1, 0));
    tbl.push_back(mk(0,0,1,1,1,1, 200,    1,   2, 0, 1, 0));
    tbl.push_back(mk(0,1,1,1,0,0,  50,    1,   3, 0, 0, 1));
    tbl.push_back(mk(1,1,0,0,0,0,   0,    0,   0, 0, 1, 0));
    tbl.push_back(mk(1,0,0,0,0,0,   0,    1,   1, 0, 1, 0));

    foreach (tbl[i]) begin
      apply(1, tbl[i].start, tbl[i].halt, tbl[i].jump, tbl[i].taken,
            tbl[i].call, tbl[i].ret, tbl[i].target);
      check_out($sformatf("vec%0d", i), tbl[i].pc, tbl[i].cnt, tbl[i].err,
                tbl[i].run, tbl[i].done);
    end

    // PC wrap on a sequential step and on a pushed return address.
    apply(1, 0, 0, 1, 1, 0, 0, 1023);
    check("wrap.jump", 32'(bus.ProgCtr), 1023);
    idle_step();
    check("wrap.seq", 32'(bus.ProgCtr), 0);
    apply(1, 0, 0, 1, 1, 0, 0, 1023);
    apply(1, 0, 0, 0, 0, 1, 0, 5);
    check("wrap.call", 32'(bus.ProgCtr), 5);
    apply(1, 0, 0, 0, 0, 0, 1, 0);
    check_out("wrap.ret", 0, 6, 0, 1, 0);

    // Reset mid-RUN with competing flags, then IDLE until Start.
    apply(0, 0, 0, 1, 1, 1, 0, 77);
    check_out("midrst", 0, 0, 0, 0, 0);
    apply(1, 0, 0, 1, 1, 0, 0, 77);
    check_out("midrst.idle", 0, 0, 0, 0, 0);
    apply(1, 1, 0, 0, 0, 0, 0, 0);
    check_out("restart", 0, 0, 0, 1, 0);

    // Retire counter saturates at all-ones.
    for (int i = 0; i < 260; i++) idle_step();
    check("sat.cnt", 32'(bus.InstCount), CNT_MAX);
    check("sat.pc", 32'(bus.ProgCtr), 260);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 2000; i++) begin
      bit rr, s, h, j, t, c, r;
      rr = ($urandom_range(63) != 0);
      s  = ($urandom_range(15) == 0);
      h  = ($urandom_range(19) == 0);
      j  = ($urandom_range(3) == 0);
      t  = $urandom_range(1) == 1;
      c  = ($urandom_range(5) == 0);
      r  = ($urandom_range(5) == 0);
      apply(rr, s, h, j, t, c, r, int'($urandom_range(PC_MOD - 1)));
      check_out($sformatf("rnd%0d", i), m_pc, m_cnt, m_err, m_run, m_done);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
